// File: rtl/address_unit.sv
// Program counter and external address bus driver for the CPU core.
// Runs the two-byte reset-vector fetch before handing the bus to fetch/decode.
module address_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
  parameter bit          USE_VECTOR   = 1'b1,
  parameter logic [15:0] PC_RESET     = 16'h0000
) (
  input  logic        clk,
  input  logic        res,
  input  logic        rdy,
  input  logic        pc_enable,
  input  logic [1:0]  address_select,
  input  logic [15:0] memory_address,
  input  logic [7:0]  alu_result,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic [7:0]  data_in,
  output logic [15:0] address_out,
  output logic [15:0] pc_out,
  output logic        vector_busy
);

  typedef enum logic [1:0] {
    V_LO = 2'd0,
    V_HI = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam state_e RESET_STATE = USE_VECTOR ? V_LO : RUN;

  state_e      state_q;
  logic [15:0] pc_q, pc_d;
  logic [15:0] last_addr_q;
  logic        busy_q;
  logic [15:0] addr_d;

  // Address bus: vector addresses during the fetch, decoder-selected source afterwards.
  always_comb begin
    // NOTE: default assignment first so every path drives addr_d and no latch is inferred.
    addr_d = pc_q;
    case (state_q)
      V_LO: addr_d = RESET_VECTOR;
      V_HI: addr_d = RESET_VECTOR + 16'd1;
      RUN: begin
        case (address_select)
          2'd0:    addr_d = pc_q;
          2'd1:    addr_d = memory_address;
          2'd2:    addr_d = {8'h00, alu_result};
          2'd3:    addr_d = last_addr_q;
          default: addr_d = pc_q;
        endcase
      end
      default: addr_d = pc_q;
    endcase
  end

  // The vector bytes fill the PC directly; load/increment only apply once running.
  always_comb begin
    pc_d = pc_q;
    case (state_q)
      V_LO: pc_d[7:0]  = data_in;
      V_HI: pc_d[15:8] = data_in;
      default: begin
        if (pc_load)        pc_d = pc_load_value;
        else if (pc_enable) pc_d = pc_q + 16'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= RESET_STATE;
      pc_q        <= PC_RESET;
      last_addr_q <= RESET_VECTOR;
      busy_q      <= USE_VECTOR;
    end else if (rdy) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      pc_q        <= pc_d;
      last_addr_q <= addr_d;
      case (state_q)
        V_LO: state_q <= V_HI;
        V_HI: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign address_out = addr_d;
  assign pc_out      = pc_q;
  assign vector_busy = busy_q;

endmodule

// File: tb/tb_address_unit.sv
// Directed bench for address_unit: vector fetch, PC update, address mux, rdy stall, reset.
// A second instance with USE_VECTOR=0 covers the no-vector reset path.
module tb_address_unit;

  logic        clk = 1'b0;
  logic        res;
  logic        rdy;
  logic        pc_enable;
  logic [1:0]  address_select;
  logic [15:0] memory_address;
  logic [7:0]  alu_result;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [7:0]  data_in;

  logic [15:0] addr, pc;
  logic        busy;
  logic [15:0] nv_addr, nv_pc;
  logic        nv_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  address_unit dut (
    .clk(clk), .res(res), .rdy(rdy), .pc_enable(pc_enable),
    .address_select(address_select), .memory_address(memory_address),
    .alu_result(alu_result), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .data_in(data_in), .address_out(addr), .pc_out(pc), .vector_busy(busy)
  );

  address_unit #(.USE_VECTOR(1'b0)) dut_nv (
    .clk(clk), .res(res), .rdy(rdy), .pc_enable(pc_enable),
    .address_select(address_select), .memory_address(memory_address),
    .alu_result(alu_result), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .data_in(data_in), .address_out(nv_addr), .pc_out(nv_pc), .vector_busy(nv_busy)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b0; rdy = 1'b1; pc_enable = 1'b0; pc_load = 1'b0; pc_load_value = 16'h0000;
    address_select = 2'd0; memory_address = 16'h0000; alu_result = 8'h00; data_in = 8'h00;
    tick();
    tick();
    n_checks++; if (addr !== 16'hFFFC) begin n_errors++; $display("FAIL reset_addr: got %h expected fffc", addr); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    n_checks++; if (pc !== 16'h0000) begin n_errors++; $display("FAIL reset_pc: got %h expected 0000", pc); end
    n_checks++; if (nv_addr !== 16'h0000) begin n_errors++; $display("FAIL nv_reset_addr: got %h expected 0000", nv_addr); end
    n_checks++; if (nv_busy !== 1'b0) begin n_errors++; $display("FAIL nv_reset_busy: got %b expected 0", nv_busy); end
  endtask

  task automatic test_vector_fetch();
    data_in = 8'h34;
    res = 1'b1;
    #1;
    n_checks++; if (addr !== 16'hFFFC) begin n_errors++; $display("FAIL vlo_addr: got %h expected fffc", addr); end
    tick();
    n_checks++; if (addr !== 16'hFFFD) begin n_errors++; $display("FAIL vhi_addr: got %h expected fffd", addr); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL vhi_busy: got %b expected 1", busy); end
    data_in = 8'h12;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL run_busy: got %b expected 0", busy); end
    n_checks++; if (pc !== 16'h1234) begin n_errors++; $display("FAIL vector_pc: got %h expected 1234", pc); end
    n_checks++; if (addr !== 16'h1234) begin n_errors++; $display("FAIL vector_addr: got %h expected 1234", addr); end
  endtask

  task automatic test_pc_wrap();
    logic [15:0] exp_pc [3];
    exp_pc[0] = 16'hFFFF; exp_pc[1] = 16'h0000; exp_pc[2] = 16'h0001;
    pc_load = 1'b1; pc_load_value = 16'hFFFE;
    tick();
    n_checks++; if (pc !== 16'hFFFE) begin n_errors++; $display("FAIL load_fffe: got %h expected fffe", pc); end
    pc_load = 1'b0; pc_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pc !== exp_pc[i]) begin n_errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, pc, exp_pc[i]); end
      n_checks++; if (addr !== exp_pc[i]) begin n_errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, addr, exp_pc[i]); end
    end
    pc_enable = 1'b0;
  endtask

  task automatic test_load_priority();
    pc_load = 1'b1; pc_load_value = 16'h0200;
    tick();
    n_checks++; if (pc !== 16'h0200) begin n_errors++; $display("FAIL load_0200: got %h expected 0200", pc); end
    pc_load_value = 16'h8000; pc_enable = 1'b1;
    tick();
    n_checks++; if (pc !== 16'h8000) begin n_errors++; $display("FAIL load_priority: got %h expected 8000", pc); end
    pc_load = 1'b0; pc_enable = 1'b0;
    tick();
    n_checks++; if (pc !== 16'h8000) begin n_errors++; $display("FAIL pc_hold: got %h expected 8000", pc); end
  endtask

  task automatic test_addr_mux();
    address_select = 2'd1; memory_address = 16'h0456;
    #1;
    n_checks++; if (addr !== 16'h0456) begin n_errors++; $display("FAIL mux_mem: got %h expected 0456", addr); end
    address_select = 2'd2; alu_result = 8'h80;
    #1;
    n_checks++; if (addr !== 16'h0080) begin n_errors++; $display("FAIL mux_zp80: got %h expected 0080", addr); end
    alu_result = 8'hFF;
    #1;
    n_checks++; if (addr !== 16'h00FF) begin n_errors++; $display("FAIL mux_zpff: got %h expected 00ff", addr); end
    tick();
    address_select = 2'd3; alu_result = 8'h12; memory_address = 16'h9999;
    #1;
    n_checks++; if (addr !== 16'h00FF) begin n_errors++; $display("FAIL mux_hold: got %h expected 00ff", addr); end
    tick();
    n_checks++; if (addr !== 16'h00FF) begin n_errors++; $display("FAIL mux_hold2: got %h expected 00ff", addr); end
    address_select = 2'd0;
    #1;
    n_checks++; if (addr !== 16'h8000) begin n_errors++; $display("FAIL mux_pc: got %h expected 8000", addr); end
  endtask

  task automatic test_rdy_freeze();
    res = 1'b0;
    #1;
    data_in = 8'hAB;
    res = 1'b1;
    tick();
    rdy = 1'b0; data_in = 8'hCD; pc_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (addr !== 16'hFFFD) begin n_errors++; $display("FAIL stall_addr[%0d]: got %h expected fffd", i, addr); end
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL stall_busy[%0d]: got %b expected 1", i, busy); end
      n_checks++; if (pc !== 16'h00AB) begin n_errors++; $display("FAIL stall_pc[%0d]: got %h expected 00ab", i, pc); end
    end
    pc_enable = 1'b0; rdy = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL stall_done_busy: got %b expected 0", busy); end
    n_checks++; if (pc !== 16'hCDAB) begin n_errors++; $display("FAIL stall_done_pc: got %h expected cdab", pc); end
    rdy = 1'b0; pc_enable = 1'b1;
    tick();
    n_checks++; if (pc !== 16'hCDAB) begin n_errors++; $display("FAIL run_stall_pc: got %h expected cdab", pc); end
    rdy = 1'b1; pc_enable = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    res = 1'b0;
    #1;
    data_in = 8'h55; res = 1'b1;
    tick();
    n_checks++; if (pc !== 16'h0055) begin n_errors++; $display("FAIL partial_pc: got %h expected 0055", pc); end
    res = 1'b0;
    #1;
    n_checks++; if (addr !== 16'hFFFC) begin n_errors++; $display("FAIL async_addr: got %h expected fffc", addr); end
    n_checks++; if (pc !== 16'h0000) begin n_errors++; $display("FAIL async_pc: got %h expected 0000", pc); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL async_busy: got %b expected 1", busy); end
    // Load/increment requests during the fetch must not disturb the vector.
    res = 1'b1; data_in = 8'h11; pc_enable = 1'b1;
    tick();
    n_checks++; if (nv_pc !== 16'h0001) begin n_errors++; $display("FAIL nv_inc: got %h expected 0001", nv_pc); end
    pc_enable = 1'b0; pc_load = 1'b1; pc_load_value = 16'h7777; data_in = 8'h22;
    tick();
    n_checks++; if (pc !== 16'h2211) begin n_errors++; $display("FAIL refetch_pc: got %h expected 2211", pc); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL refetch_busy: got %b expected 0", busy); end
    pc_load = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    exp = 16'h2211;
    pc_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = exp + 16'd1;
      tick();
      n_checks++; if (pc !== exp) begin n_errors++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, pc, exp); end
    end
    pc_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vector_fetch();
    test_pc_wrap();
    test_load_priority();
    test_addr_mux();
    test_rdy_freeze();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
